tvip_axi_channel_buffer: RTL
============================

# tvip_axi_channel_buffer

Parametrised, burst-aware buffer for one AXI valid/ready channel (AW, W, B, AR or R), generalising the fixed-width channel signals of the TVIP AXI interface into a reusable, configurable-depth storage stage. It has an optional store-and-forward packet mode that holds W or R beats until a complete burst (`last` seen) is buffered. It falls back to cut-through when the burst exceeds `DEPTH`. Instances sit between the TVIP AXI agents and the DUT ports or inside TVIP slave models, one per channel, with `WIDTH` set to that channel's packed payload (id/addr/len/size/burst/qos, or data/strb, or id/resp).

## Interface
- `WIDTH`, 64: payload bits per beat (≥1).
- `DEPTH`, 4: storage entries; power of two, ≥2.
- `PACKET_MODE`, 0: 0 = cut-through; 1 = store-and-forward on `last`.
- `CW`, derived, `$clog2(DEPTH)+1`: counter width.
- `aclk` in 1: clock; all logic on rising edge.
- `areset` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: buffer can accept a beat.
- `in_payload` in WIDTH: upstream beat payload.
- `in_last` in 1: last beat of burst; tie 1 for AW/AR/B.
- `out_valid` out 1: downstream beat valid.
- `out_ready` in 1: downstream accepts beat.
- `out_payload` out WIDTH: head-of-buffer payload.
- `out_last` out 1: head-of-buffer last flag.
- `count` out CW: beats currently stored (0..DEPTH).
- `packets` out CW: stored beats with `last`=1 (0..DEPTH).

## Operation
- Storage: DEPTH entries of {last, payload}. Write and read pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
- Push = `in_valid && in_ready`: write at wptr, wptr+1.
- Pop = `out_valid && out_ready`: rptr+1.
- `in_ready` = `!areset && count < DEPTH`. It depends only on registered state, with no combinational path from `out_ready`. When full, a same-cycle pop does not open `in_ready`.
- `count` next = count + push − pop. Push and pop in the same cycle leave it unchanged.
- `packets` next = packets + (push && in_last) − (pop && out_last).
- `out_payload`/`out_last` = entry at rptr. These are undefined (don't care) when `out_valid`=0.
- `PACKET_MODE`=0: `out_valid` = `count != 0`.
- `PACKET_MODE`=1: `out_valid` = `count != 0 && (packets != 0 || count == DEPTH)`.
  - The `count == DEPTH` term is the cut-through fallback that prevents deadlock on bursts longer than DEPTH.
- AXI stability: once `out_valid`=1 it holds, with `out_payload`/`out_last` stable, until a pop. This holds by construction, because count and packets only decrease on pop.
- Upstream may drop `in_valid` without a push; nothing is latched.
- Reset: all stored beats are discarded. wptr, rptr, count and packets all go to 0.

## Timing
- Reset values:
  - During the `areset` cycle: `in_ready`=0.
  - From the first cycle after `areset` deasserts: `in_ready`=1 (while not full).
  - `out_valid`=0, `count`=0, `packets`=0.
- Latency, cut-through mode: a beat pushed at edge N gives `out_valid`=1 after edge N, so it is poppable at edge N+1.
- Latency, packet mode: `out_valid` rises the cycle after the push of the `last` beat, or the push that makes `count`=DEPTH.
- Throughput: one beat per cycle sustained, with continuous `in_valid` and `out_ready`, for any DEPTH ≥2.
- Full (`count`=DEPTH): `in_ready`=0 for that cycle even if `out_ready`=1. `in_ready` returns the cycle after the pop.
- Empty: `out_valid`=0. A push into an empty buffer is not bypassed to the output in the same cycle.
- Reset mid-operation:
  - Any beat presented in the reset cycle is not accepted.
  - `out_valid` and `count` are 0 on the following cycle.

## Test plan
- Reset/idle, DEPTH=4:
  - Stimulus: assert `areset` 2 cycles, then release.
  - Required: `in_ready`=0 while reset is high, then 1; `out_valid`=0; `count`=0; `packets`=0.
- Streaming, cut-through, DEPTH=4:
  - Stimulus: push 16 beats with payload 0..15, `out_ready`=1 constantly.
  - Required: beats out in order 0..15, one per cycle after 1-cycle latency; `count` ≤1 throughout.
- Full/wrap, DEPTH=4:
  - Stimulus: `out_ready`=0, push 4 beats (A..D).
  - Required: `in_ready`=0 and `count`=4 after the 4th push.
  - Stimulus: raise `out_ready` for 1 cycle.
  - Required: A pops; `in_ready`=1 next cycle.
  - Stimulus: push E, then drain.
  - Required: order B, C, D, E, exercising pointer wrap.
- Packet mode, DEPTH=8:
  - Stimulus: push a 3-beat burst (`last` on beat 3) with `out_ready`=1.
  - Required: `out_valid` stays 0 until the cycle after beat 3 is pushed; `packets`=1; then 3 beats out back-to-back and `packets` returns to 0.
- Packet-mode fallback, DEPTH=4:
  - Stimulus: push a 6-beat burst.
  - Required: `out_valid` rises when `count`=4 with `packets`=0; all 6 beats delivered in order; no deadlock.
- Mid-operation reset:
  - Stimulus: with 3 beats stored, assert `areset` for 1 cycle while also presenting a new beat.
  - Required: beat not accepted; `count`=0 and `out_valid`=0 next cycle; a subsequent push of 0x5A emerges as the first beat.

Source files
------------

// File: rtl/tvip_axi_channel_buffer.sv
// Burst-aware FIFO for one AXI valid/ready channel. Store-and-forward mode holds beats until a
// complete burst is stored. It falls back to cut-through when the buffer is full.
module tvip_axi_channel_buffer #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PACKET_MODE = 0,
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic             i_aclk,
  input  logic             i_areset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_payload,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_payload,
  output logic             o_out_last,
  output logic [CW-1:0]    o_count,
  output logic [CW-1:0]    o_packets
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_packets;

  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_nonempty;
  logic [WIDTH:0]  w_head;

  // Ready is derived from registered state only, so a pop never opens it in the same cycle.
  always_comb begin
    w_full     = (r_count == CW'(DEPTH));
    w_nonempty = (r_count != '0);
    o_in_ready = !i_areset && !w_full;
    if (PACKET_MODE == 0) begin
      o_out_valid = w_nonempty;
    end else begin
      // A full buffer releases beats even without a complete burst, avoiding deadlock.
      o_out_valid = w_nonempty && ((r_packets != '0) || w_full);
    end
    w_push = i_in_valid && o_in_ready;
    w_pop  = o_out_valid && i_out_ready;
  end

  assign w_head        = r_mem[r_rptr];
  assign o_out_payload = w_head[WIDTH-1:0];
  assign o_out_last    = w_head[WIDTH];
  assign o_count       = r_count;
  assign o_packets     = r_packets;

  always_ff @(posedge i_aclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_in_last, i_in_payload};
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_packets <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_packets <= r_packets + CW'(w_push && i_in_last) - CW'(w_pop && o_out_last);
    end
  end

endmodule
